// File: rtl/ex_mem_latch_if.sv
// EX/MEM stage bus: EX-side inputs and registered MEM-side / forwarding outputs.
interface ex_mem_latch_if #(
    parameter int unsigned NB_DATA  = 32,
    parameter int unsigned NB_REG   = 5,
    parameter int unsigned NB_WIDTH = 2
);
    logic                i_valid;
    logic                i_stall;
    logic                i_flush;
    logic [NB_DATA-1:0]  i_alu_result;
    logic [NB_DATA-1:0]  i_rt_data;
    logic [NB_REG-1:0]   i_write_reg;
    logic                i_reg_write;
    logic                i_mem_read;
    logic                i_mem_write;
    logic                i_mem_to_reg;
    logic [NB_WIDTH-1:0] i_mem_width;
    logic                i_mem_unsigned;

    logic                o_valid;
    logic [NB_DATA-1:0]  o_alu_result;
    logic [NB_DATA-1:0]  o_store_data;
    logic [3:0]          o_byte_en;
    logic [NB_REG-1:0]   o_write_reg;
    logic                o_reg_write;
    logic                o_mem_read;
    logic                o_mem_write;
    logic                o_mem_to_reg;
    logic                o_mem_unsigned;
    logic [NB_WIDTH-1:0] o_mem_width;
    logic                o_fwd_valid;
    logic [NB_REG-1:0]   o_fwd_dst;
    logic                o_load_hazard;
    logic                o_misaligned;
    logic [NB_DATA-1:0]  o_bad_addr;

    modport master (
        output i_valid, i_stall, i_flush, i_alu_result, i_rt_data, i_write_reg,
               i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_mem_width,
               i_mem_unsigned,
        input  o_valid, o_alu_result, o_store_data, o_byte_en, o_write_reg,
               o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_mem_unsigned,
               o_mem_width, o_fwd_valid, o_fwd_dst, o_load_hazard, o_misaligned,
               o_bad_addr
    );

    modport slave (
        input  i_valid, i_stall, i_flush, i_alu_result, i_rt_data, i_write_reg,
               i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_mem_width,
               i_mem_unsigned,
        output o_valid, o_alu_result, o_store_data, o_byte_en, o_write_reg,
               o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_mem_unsigned,
               o_mem_width, o_fwd_valid, o_fwd_dst, o_load_hazard, o_misaligned,
               o_bad_addr
    );
endinterface

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with stall/flush, store lane alignment and forwarding info.
// Optional misaligned-access trap enabled by defining EX_MEM_MISALIGN_TRAP_EN.
module ex_mem_latch #(
    parameter int unsigned NB_DATA  = 32,
    parameter int unsigned NB_REG   = 5,
    parameter int unsigned NB_WIDTH = 2
) (
    input  logic           i_clk,
    input  logic           i_reset,
    ex_mem_latch_if.slave  bus
);
    localparam logic [NB_WIDTH-1:0] W_BYTE = NB_WIDTH'(0);
    localparam logic [NB_WIDTH-1:0] W_HALF = NB_WIDTH'(1);
    localparam logic [NB_WIDTH-1:0] W_WORD = NB_WIDTH'(2);

    logic                valid_q,    valid_d;
    logic [NB_DATA-1:0]  alu_q,      alu_d;
    logic [NB_DATA-1:0]  store_q,    store_d;
    logic [3:0]          be_q,       be_d;
    logic [NB_REG-1:0]   wreg_q,     wreg_d;
    logic                regw_q,     regw_d;
    logic                mrd_q,      mrd_d;
    logic                mwr_q,      mwr_d;
    logic                m2r_q,      m2r_d;
    logic                uns_q,      uns_d;
    logic [NB_WIDTH-1:0] width_q,    width_d;
    logic                misal_q,    misal_d;
    logic [NB_DATA-1:0]  bad_addr_q, bad_addr_d;

    logic [1:0]          addr_c;
    logic [3:0]          lane_be_c;
    logic [NB_DATA-1:0]  lane_data_c;
    logic                misalign_c;
    logic                bubble_c;

    // Store lane replication and byte enables from the low address bits
    always_comb begin
        addr_c      = bus.i_alu_result[1:0];
        lane_be_c   = 4'b0000;
        lane_data_c = bus.i_rt_data;
        case (bus.i_mem_width)
            W_BYTE: begin
                lane_be_c   = 4'(4'b0001 << addr_c);
                lane_data_c = NB_DATA'({4{bus.i_rt_data[7:0]}});
            end
            W_HALF: begin
                lane_be_c   = addr_c[1] ? 4'b1100 : 4'b0011;
                lane_data_c = NB_DATA'({2{bus.i_rt_data[15:0]}});
            end
            W_WORD:  lane_be_c = 4'b1111;
            default: lane_be_c = 4'b0000;
        endcase
        if (!bus.i_mem_write) lane_be_c = 4'b0000;
    end

`ifdef EX_MEM_MISALIGN_TRAP_EN
    always_comb begin
        misalign_c = (bus.i_mem_read | bus.i_mem_write) &
                     (((bus.i_mem_width == W_HALF) & addr_c[0]) |
                      ((bus.i_mem_width == W_WORD) & (addr_c != 2'b00)));
    end
`else
    assign misalign_c = 1'b0;
`endif

    // Next state: flush > stall > capture; invalid or trapped captures become bubbles
    always_comb begin
        valid_d    = valid_q;
        alu_d      = alu_q;
        store_d    = store_q;
        be_d       = be_q;
        wreg_d     = wreg_q;
        regw_d     = regw_q;
        mrd_d      = mrd_q;
        mwr_d      = mwr_q;
        m2r_d      = m2r_q;
        uns_d      = uns_q;
        width_d    = width_q;
        misal_d    = 1'b0;
        bad_addr_d = bad_addr_q;

        bubble_c = bus.i_flush |
                   (~bus.i_stall & (~bus.i_valid | misalign_c));

        if (bubble_c) begin
            valid_d = 1'b0;
            alu_d   = '0;
            store_d = '0;
            be_d    = 4'b0000;
            wreg_d  = '0;
            regw_d  = 1'b0;
            mrd_d   = 1'b0;
            mwr_d   = 1'b0;
            m2r_d   = 1'b0;
            uns_d   = 1'b0;
            width_d = '0;
        end else if (!bus.i_stall) begin
            valid_d = 1'b1;
            alu_d   = bus.i_alu_result;
            store_d = lane_data_c;
            be_d    = lane_be_c;
            wreg_d  = bus.i_write_reg;
            regw_d  = bus.i_reg_write & (bus.i_write_reg != '0);
            mrd_d   = bus.i_mem_read;
            mwr_d   = bus.i_mem_write;
            m2r_d   = bus.i_mem_to_reg;
            uns_d   = bus.i_mem_unsigned;
            width_d = bus.i_mem_width;
        end

        if (!bus.i_flush && !bus.i_stall && bus.i_valid && misalign_c) begin
            misal_d    = 1'b1;
            bad_addr_d = bus.i_alu_result;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q    <= 1'b0;
            alu_q      <= '0;
            store_q    <= '0;
            be_q       <= 4'b0000;
            wreg_q     <= '0;
            regw_q     <= 1'b0;
            mrd_q      <= 1'b0;
            mwr_q      <= 1'b0;
            m2r_q      <= 1'b0;
            uns_q      <= 1'b0;
            width_q    <= '0;
            misal_q    <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            valid_q    <= valid_d;
            alu_q      <= alu_d;
            store_q    <= store_d;
            be_q       <= be_d;
            wreg_q     <= wreg_d;
            regw_q     <= regw_d;
            mrd_q      <= mrd_d;
            mwr_q      <= mwr_d;
            m2r_q      <= m2r_d;
            uns_q      <= uns_d;
            width_q    <= width_d;
            misal_q    <= misal_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    assign bus.o_valid        = valid_q;
    assign bus.o_alu_result   = alu_q;
    assign bus.o_store_data   = store_q;
    assign bus.o_byte_en      = be_q;
    assign bus.o_write_reg    = wreg_q;
    assign bus.o_reg_write    = regw_q;
    assign bus.o_mem_read     = mrd_q;
    assign bus.o_mem_write    = mwr_q;
    assign bus.o_mem_to_reg   = m2r_q;
    assign bus.o_mem_unsigned = uns_q;
    assign bus.o_mem_width    = width_q;
    assign bus.o_misaligned   = misal_q;
    assign bus.o_bad_addr     = bad_addr_q;

    // Forwarding view: loads in MEM cannot forward and signal a hazard instead
    assign bus.o_fwd_valid   = valid_q & regw_q & ~mrd_q;
    assign bus.o_load_hazard = valid_q & regw_q & mrd_q;
    assign bus.o_fwd_dst     = wreg_q;
endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed self-checking bench for ex_mem_latch.
module tb_ex_mem_latch;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    ex_mem_latch_if bus ();

    ex_mem_latch dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rt,
                         input logic [4:0] wr, input logic rw, input logic mr,
                         input logic mw, input logic m2r, input logic [1:0] w,
                         input logic uns);
        bus.i_valid        = v;
        bus.i_alu_result   = alu;
        bus.i_rt_data      = rt;
        bus.i_write_reg    = wr;
        bus.i_reg_write    = rw;
        bus.i_mem_read     = mr;
        bus.i_mem_write    = mw;
        bus.i_mem_to_reg   = m2r;
        bus.i_mem_width    = w;
        bus.i_mem_unsigned = uns;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1);
        tick();
        tick();
        n_tests++;
        if ({bus.o_valid, bus.o_reg_write, bus.o_mem_read, bus.o_mem_write,
             bus.o_mem_to_reg, bus.o_mem_unsigned} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000", {bus.o_valid, bus.o_reg_write,
                     bus.o_mem_read, bus.o_mem_write, bus.o_mem_to_reg, bus.o_mem_unsigned});
        end
        n_tests++;
        if ({bus.o_alu_result, bus.o_store_data, bus.o_byte_en, bus.o_write_reg,
             bus.o_mem_width, bus.o_misaligned, bus.o_bad_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: alu=%h sd=%h be=%b wr=%0d bad=%h mis=%b want all 0",
                     bus.o_alu_result, bus.o_store_data, bus.o_byte_en, bus.o_write_reg,
                     bus.o_bad_addr, bus.o_misaligned);
        end
        n_tests++;
        if ({bus.o_fwd_valid, bus.o_load_hazard, bus.o_fwd_dst} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_fwd: fv=%b lh=%b dst=%0d want 0", bus.o_fwd_valid,
                     bus.o_load_hazard, bus.o_fwd_dst);
        end
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_alu();
        drive(1'b1, 32'h0000_0010, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
        tick();
        n_tests++;
        if ({bus.o_valid, bus.o_alu_result, bus.o_fwd_valid, bus.o_fwd_dst, bus.o_reg_write}
            !== {1'b1, 32'h10, 1'b1, 5'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL alu_fwd: v=%b alu=%h fv=%b dst=%0d rw=%b want 1 10 1 8 1",
                     bus.o_valid, bus.o_alu_result, bus.o_fwd_valid, bus.o_fwd_dst,
                     bus.o_reg_write);
        end
        n_tests++;
        if ({bus.o_load_hazard, bus.o_byte_en} !== 5'b0) begin
            n_fail++;
            $display("FAIL alu_nostore: lh=%b be=%b want 0 0000", bus.o_load_hazard, bus.o_byte_en);
        end
    endtask

    task automatic test_store_align();
        logic [31:0] addr [5];
        logic [31:0] rt   [5];
        logic [1:0]  wd   [5];
        logic        mw   [5];
        logic [3:0]  exp_be [5];
        logic [31:0] exp_sd [5];
        addr[0] = 32'h3;   rt[0] = 32'h0000_00AB; wd[0] = 2'b00; mw[0] = 1'b1;
        exp_be[0] = 4'b1000; exp_sd[0] = 32'hABAB_ABAB;
        addr[1] = 32'h2;   rt[1] = 32'h0000_1234; wd[1] = 2'b01; mw[1] = 1'b1;
        exp_be[1] = 4'b1100; exp_sd[1] = 32'h1234_1234;
        addr[2] = 32'h100; rt[2] = 32'hDEAD_BEEF; wd[2] = 2'b10; mw[2] = 1'b1;
        exp_be[2] = 4'b1111; exp_sd[2] = 32'hDEAD_BEEF;
        addr[3] = 32'h41;  rt[3] = 32'h1122_3344; wd[3] = 2'b00; mw[3] = 1'b1;
        exp_be[3] = 4'b0010; exp_sd[3] = 32'h4444_4444;
        addr[4] = 32'h8;   rt[4] = 32'h5566_7788; wd[4] = 2'b11; mw[4] = 1'b1;
        exp_be[4] = 4'b0000; exp_sd[4] = 32'h5566_7788;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, addr[i], rt[i], 5'd0, 1'b0, 1'b0, mw[i], 1'b0, wd[i], 1'b0);
            tick();
            n_tests++;
            if ({bus.o_byte_en, bus.o_store_data, bus.o_mem_write} !== {exp_be[i], exp_sd[i], 1'b1}) begin
                n_fail++;
                $display("FAIL store_lane[%0d]: be=%b sd=%h mw=%b want %b %h 1", i,
                         bus.o_byte_en, bus.o_store_data, bus.o_mem_write, exp_be[i], exp_sd[i]);
            end
        end
        drive(1'b1, 32'h3, 32'hAB, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1);
        tick();
        n_tests++;
        if ({bus.o_byte_en, bus.o_mem_unsigned, bus.o_mem_to_reg} !== 6'b0000_11) begin
            n_fail++;
            $display("FAIL load_no_be: be=%b uns=%b m2r=%b want 0000 1 1", bus.o_byte_en,
                     bus.o_mem_unsigned, bus.o_mem_to_reg);
        end
    endtask

    task automatic test_load_hazard();
        drive(1'b1, 32'h20, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        tick();
        n_tests++;
        if ({bus.o_load_hazard, bus.o_fwd_valid, bus.o_fwd_dst} !== {1'b1, 1'b0, 5'd9}) begin
            n_fail++;
            $display("FAIL load_r9: lh=%b fv=%b dst=%0d want 1 0 9", bus.o_load_hazard,
                     bus.o_fwd_valid, bus.o_fwd_dst);
        end
        drive(1'b1, 32'h20, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        tick();
        n_tests++;
        if ({bus.o_reg_write, bus.o_load_hazard, bus.o_fwd_valid, bus.o_valid} !== 4'b0001) begin
            n_fail++;
            $display("FAIL load_r0: rw=%b lh=%b fv=%b v=%b want 0 0 0 1", bus.o_reg_write,
                     bus.o_load_hazard, bus.o_fwd_valid, bus.o_valid);
        end
    endtask

    task automatic test_bubble();
        drive(1'b0, 32'h44, 32'h55, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0);
        tick();
        n_tests++;
        if ({bus.o_valid, bus.o_mem_write, bus.o_reg_write, bus.o_alu_result, bus.o_byte_en}
            !== '0) begin
            n_fail++;
            $display("FAIL invalid_bubble: v=%b mw=%b rw=%b alu=%h be=%b want all 0",
                     bus.o_valid, bus.o_mem_write, bus.o_reg_write, bus.o_alu_result, bus.o_byte_en);
        end
    endtask

    task automatic test_stall_flush();
        drive(1'b1, 32'h1234_5678, 32'hCAFE_F00D, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0);
        tick();
        bus.i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h9000_0000 + 32'(i), 32'h0000_1111 * 32'(i + 1), 5'(i + 10), 1'b0,
                  1'b1, 1'b0, 1'b1, 2'b00, 1'b1);
            tick();
            n_tests++;
            if ({bus.o_valid, bus.o_alu_result, bus.o_store_data, bus.o_byte_en, bus.o_write_reg,
                 bus.o_mem_write, bus.o_mem_read}
                !== {1'b1, 32'h1234_5678, 32'hCAFE_F00D, 4'b1111, 5'd5, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: v=%b alu=%h sd=%h be=%b wr=%0d mw=%b mr=%b", i,
                         bus.o_valid, bus.o_alu_result, bus.o_store_data, bus.o_byte_en,
                         bus.o_write_reg, bus.o_mem_write, bus.o_mem_read);
            end
        end
        bus.i_flush = 1'b1;
        tick();
        n_tests++;
        if ({bus.o_valid, bus.o_mem_write, bus.o_alu_result, bus.o_byte_en, bus.o_write_reg}
            !== '0) begin
            n_fail++;
            $display("FAIL stall_flush: v=%b mw=%b alu=%h be=%b wr=%0d want all 0",
                     bus.o_valid, bus.o_mem_write, bus.o_alu_result, bus.o_byte_en, bus.o_write_reg);
        end
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h0000_0ABC, 32'h7, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0);
        tick();
        n_tests++;
        if (bus.o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: v=%b want 1", bus.o_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.o_valid, bus.o_alu_result, bus.o_reg_write, bus.o_mem_write, bus.o_byte_en,
             bus.o_write_reg, bus.o_fwd_valid} !== '0) begin
            n_fail++;
            $display("FAIL areset_mid: v=%b alu=%h rw=%b mw=%b be=%b wr=%0d fv=%b want all 0",
                     bus.o_valid, bus.o_alu_result, bus.o_reg_write, bus.o_mem_write,
                     bus.o_byte_en, bus.o_write_reg, bus.o_fwd_valid);
        end
        tick();
        rst = 1'b0;
        drive(1'b1, 32'h0000_0024, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
        tick();
        n_tests++;
        if ({bus.o_valid, bus.o_alu_result, bus.o_fwd_valid, bus.o_fwd_dst}
            !== {1'b1, 32'h24, 1'b1, 5'd3}) begin
            n_fail++;
            $display("FAIL areset_after: v=%b alu=%h fv=%b dst=%0d want 1 24 1 3", bus.o_valid,
                     bus.o_alu_result, bus.o_fwd_valid, bus.o_fwd_dst);
        end
    endtask

    task automatic test_misalign();
        logic       exp_v;
        logic       exp_mis;
        logic [31:0] exp_bad;
`ifdef EX_MEM_MISALIGN_TRAP_EN
        exp_v = 1'b0; exp_mis = 1'b1; exp_bad = 32'h6;
`else
        exp_v = 1'b1; exp_mis = 1'b0; exp_bad = 32'h0;
`endif
        drive(1'b1, 32'h0000_0006, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        tick();
        n_tests++;
        if ({bus.o_valid, bus.o_misaligned, bus.o_bad_addr} !== {exp_v, exp_mis, exp_bad}) begin
            n_fail++;
            $display("FAIL misalign_word: v=%b mis=%b bad=%h want %b %b %h", bus.o_valid,
                     bus.o_misaligned, bus.o_bad_addr, exp_v, exp_mis, exp_bad);
        end
        drive(1'b1, 32'h0000_0008, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
        tick();
        n_tests++;
        if ({bus.o_valid, bus.o_misaligned, bus.o_bad_addr} !== {1'b1, 1'b0, exp_bad}) begin
            n_fail++;
            $display("FAIL misalign_after: v=%b mis=%b bad=%h want 1 0 %h", bus.o_valid,
                     bus.o_misaligned, bus.o_bad_addr, exp_bad);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_alu();
        test_store_align();
        test_load_hazard();
        test_bubble();
        test_stall_flush();
        test_async_reset();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
